// File: rtl/equiv_mismatch_monitor.sv
// Equivalence monitor: compares paired implementation outputs after a settle window,
// counts and captures miscompares. Define EQUIV_MON_ASSERT_EN to add a formal assertion.
module equiv_mismatch_monitor #(
   parameter int unsigned WIDTH  = 91,
   parameter int unsigned SETTLE = 2,
   parameter int unsigned CNT_W  = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clear,
   input  logic [WIDTH-1:0] y_1,
   input  logic [WIDTH-1:0] y_2,
   output logic             mismatch,
   output logic             first_valid,
   output logic [CNT_W-1:0] first_cycle,
   output logic [WIDTH-1:0] first_diff,
   output logic [CNT_W-1:0] mismatch_cnt,
   output logic [CNT_W-1:0] cycle_cnt,
   output logic             done
);

   localparam int unsigned      SC_W        = (SETTLE > 1) ? $clog2(SETTLE + 1) : 1;
   localparam logic [SC_W-1:0]  SETTLE_INIT = SC_W'(SETTLE);
   localparam logic [CNT_W-1:0] CNT_MAX     = '1;

   typedef enum logic [1:0] {S_SETTLE, S_COMPARE, S_DONE} state_t;

   state_t           state, state_nx;
   logic [SC_W-1:0]  settle_ctr, settle_nx;
   logic [CNT_W-1:0] cycle_nx, mcnt_nx, fcyc_nx;
   logic [WIDTH-1:0] fdiff_nx;
   logic             fvalid_nx, mm_nx, cmp;

   // Case inequality so X/Z differences are reported rather than masked.
   assign cmp  = (y_1 !== y_2);
   assign done = (state == S_DONE);

   always_comb begin
      state_nx  = state;
      settle_nx = settle_ctr;
      cycle_nx  = cycle_cnt;
      mcnt_nx   = mismatch_cnt;
      fvalid_nx = first_valid;
      fcyc_nx   = first_cycle;
      fdiff_nx  = first_diff;
      mm_nx     = 1'b0;
      if (clear) begin
         state_nx  = S_SETTLE;
         settle_nx = SETTLE_INIT;
         cycle_nx  = '0;
         mcnt_nx   = '0;
         fvalid_nx = 1'b0;
         fcyc_nx   = '0;
         fdiff_nx  = '0;
      end else begin
         case (state)
            S_SETTLE: begin
               // The edge that takes the counter from 1 to 0 (or sees 0) also enters COMPARE.
               if (settle_ctr <= SC_W'(1)) begin
                  settle_nx = '0;
                  state_nx  = S_COMPARE;
               end else begin
                  settle_nx = settle_ctr - 1'b1;
               end
            end
            S_COMPARE: begin
               if (en) begin
                  mm_nx = cmp;
                  if (cmp) begin
                     if (mismatch_cnt != CNT_MAX) mcnt_nx = mismatch_cnt + 1'b1;
                     if (!first_valid) begin
                        fvalid_nx = 1'b1;
                        fcyc_nx   = cycle_cnt;
                        fdiff_nx  = y_1 ^ y_2;
                     end
                  end
                  if (cycle_cnt != CNT_MAX) cycle_nx = cycle_cnt + 1'b1;
                  if (cycle_nx == CNT_MAX) state_nx = S_DONE;
               end
            end
            S_DONE: ;
            default: state_nx = S_SETTLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_SETTLE;
         settle_ctr   <= SETTLE_INIT;
         cycle_cnt    <= '0;
         mismatch_cnt <= '0;
         first_valid  <= 1'b0;
         first_cycle  <= '0;
         first_diff   <= '0;
         mismatch     <= 1'b0;
      end else begin
         state        <= state_nx;
         settle_ctr   <= settle_nx;
         cycle_cnt    <= cycle_nx;
         mismatch_cnt <= mcnt_nx;
         first_valid  <= fvalid_nx;
         first_cycle  <= fcyc_nx;
         first_diff   <= fdiff_nx;
         mismatch     <= mm_nx;
      end
   end

`ifdef EQUIV_MON_ASSERT_EN
   always_ff @(posedge clk) begin
      if (rst_n && !clear)
         assert (!(state == S_COMPARE && en && (y_1 !== y_2)));
   end
`else
`endif

endmodule

// File: tb/tb_equiv_mismatch_monitor.sv
// Scoreboard bench for equiv_mismatch_monitor: directed scenarios plus random
// stimulus checked against a cycle-level behavioural model.
module tb_equiv_mismatch_monitor;

   localparam int unsigned W   = 91;
   localparam int unsigned CW  = 4;
   localparam int unsigned ST  = 2;
   localparam int          MAX = (1 << CW) - 1;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          en = 1'b0;
   logic          clear = 1'b0;
   logic [W-1:0]  y_1 = '0;
   logic [W-1:0]  y_2 = '0;
   logic          mismatch, first_valid, done;
   logic [CW-1:0] first_cycle, mismatch_cnt, cycle_cnt;
   logic [W-1:0]  first_diff;

   equiv_mismatch_monitor #(.WIDTH(W), .SETTLE(ST), .CNT_W(CW)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clear(clear), .y_1(y_1), .y_2(y_2),
      .mismatch(mismatch), .first_valid(first_valid), .first_cycle(first_cycle),
      .first_diff(first_diff), .mismatch_cnt(mismatch_cnt), .cycle_cnt(cycle_cnt),
      .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic          mm;
      logic          fv;
      logic [CW-1:0] fc;
      logic [W-1:0]  fd;
      logic [CW-1:0] mc;
      logic [CW-1:0] cc;
      logic          dn;
   } exp_t;

   exp_t exp_q[$];
   int   total = 0;
   int   bad = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   // Behavioural model: settle length in clocks, then count compared cycles.
   int           sl, cc_m, mc_m, fc_m;
   bit           in_cmp, dn_m, fv_m, mm_m;
   logic [W-1:0] fd_m;

   task automatic model_reset();
      sl = (ST == 0) ? 1 : ST;
      in_cmp = 0; dn_m = 0; fv_m = 0; mm_m = 0;
      cc_m = 0; mc_m = 0; fc_m = 0; fd_m = '0;
   endtask

   task automatic model_step(input bit r, input bit e, input bit c,
                             input logic [W-1:0] a, input logic [W-1:0] b);
      if (!r || c) begin
         model_reset();
      end else begin
         mm_m = 0;
         if (dn_m) begin
         end else if (!in_cmp) begin
            sl--;
            if (sl <= 0) in_cmp = 1;
         end else if (e) begin
            if (a !== b) begin
               mm_m = 1;
               if (mc_m < MAX) mc_m++;
               if (!fv_m) begin
                  fv_m = 1; fc_m = cc_m; fd_m = a ^ b;
               end
            end
            cc_m++;
            if (cc_m == MAX) begin
               dn_m = 1; in_cmp = 0;
            end
         end
      end
   endtask

   task automatic step(input bit r, input bit e, input bit c,
                       input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t x;
      @(negedge clk);
      rst_n = r; en = e; clear = c; y_1 = a; y_2 = b;
      if (!r) begin
         #1;
         chk("async_reset", {mismatch, first_valid, done, cycle_cnt, mismatch_cnt, first_cycle}, '0);
         chk("async_reset_diff", first_diff, '0);
      end
      model_step(r, e, c, a, b);
      x.mm = mm_m; x.fv = fv_m; x.fc = CW'(fc_m); x.fd = fd_m;
      x.mc = CW'(mc_m); x.cc = CW'(cc_m); x.dn = dn_m;
      exp_q.push_back(x);
   endtask

   task automatic after_edge();
      @(posedge clk);
      #2;
   endtask

   function automatic logic [W-1:0] rnd_vec();
      logic [95:0] t;
      t = {$urandom, $urandom, $urandom};
      return t[W-1:0];
   endfunction

   // Monitor: one expected record per clock edge.
   initial begin
      exp_t x;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            chk("mismatch", mismatch, x.mm);
            chk("first_valid", first_valid, x.fv);
            chk("first_cycle", first_cycle, x.fc);
            chk("first_diff", first_diff, x.fd);
            chk("mismatch_cnt", mismatch_cnt, x.mc);
            chk("cycle_cnt", cycle_cnt, x.cc);
            chk("done", done, x.dn);
         end
      end
   end

   initial begin
      logic [W-1:0] v, bit90;
      int           k;
      bit90 = '0;
      bit90[90] = 1'b1;
      model_reset();

      // 1: settle then 8 equal compares
      step(0, 0, 0, '0, '0);
      for (int i = 0; i < 10; i++) begin
         v = rnd_vec();
         step(1, 1, 0, v, v);
      end
      after_edge();
      chk("t1_cycle_cnt", cycle_cnt, 8);
      chk("t1_first_valid", first_valid, 0);

      // 2/3: mismatches at compare cycles 3 and 5, then clear with a mismatch
      step(1, 1, 1, '0, '0);
      step(1, 1, 0, '0, '0);
      step(1, 1, 0, '0, '0);
      for (int i = 0; i < 6; i++) begin
         v = rnd_vec();
         if (i == 3) step(1, 1, 0, v, v ^ bit90);
         else if (i == 5) step(1, 1, 0, v, ~v);
         else step(1, 1, 0, v, v);
         if (i == 3) begin
            after_edge();
            chk("t2_pulse", mismatch, 1);
            chk("t2_first_cycle", first_cycle, 3);
            chk("t2_first_diff", first_diff, bit90);
            chk("t2_mismatch_cnt", mismatch_cnt, 1);
         end
      end
      after_edge();
      chk("t3_first_cycle", first_cycle, 3);
      chk("t3_mismatch_cnt", mismatch_cnt, 2);
      v = rnd_vec();
      step(1, 1, 1, v, ~v);
      after_edge();
      chk("t3_clear", {mismatch, first_valid, done, cycle_cnt, mismatch_cnt}, '0);

      // 4: saturation to done, later mismatches ignored
      for (int i = 0; i < 22; i++) begin
         v = rnd_vec();
         step(1, 1, 0, v, v);
      end
      after_edge();
      chk("t4_cycle_cnt", cycle_cnt, 15);
      chk("t4_done", done, 1);
      for (int i = 0; i < 3; i++) begin
         v = rnd_vec();
         step(1, 1, 0, v, ~v);
      end
      after_edge();
      chk("t4_ignored", {mismatch, mismatch_cnt, first_valid}, '0);

      // 5: en=0 with differing vectors, then async reset mid-run
      step(1, 0, 1, '0, '0);
      for (int i = 0; i < 6; i++) begin
         v = rnd_vec();
         step(1, 0, 0, v, ~v);
      end
      after_edge();
      chk("t5_no_count", {mismatch, cycle_cnt, mismatch_cnt}, '0);
      for (int i = 0; i < 3; i++) begin
         v = rnd_vec();
         step(1, 1, 0, v, v ^ 91'd1);
      end
      step(0, 1, 0, '0, '1);

      // random run
      for (int i = 0; i < 700; i++) begin
         v = rnd_vec();
         k = $urandom_range(0, 99);
         step(($urandom_range(0, 199) != 0),
              ($urandom_range(0, 9) < 8),
              ($urandom_range(0, 15) == 0),
              v,
              (k < 30) ? (v ^ (W'(1) << $urandom_range(0, W - 1))) : v);
      end

      k = 0;
      while (exp_q.size() > 0 && k < 10) begin
         @(posedge clk);
         k++;
      end
      #3;
      if (exp_q.size() > 0) begin
         total++;
         bad++;
         $display("FAIL drain: %0d records left, required 0", exp_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
